// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone RAM arbiter: FSM state encodings, the
// stall counter width and a packed view of a master's control/address inputs.
// No ports (package).
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int CNT_W = 16;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT0 = 2'd1;
   localparam logic [1:0] ST_GRANT1 = 2'd2;

   // Control/address part of one master request (data is width-parameterized
   // and carried separately).
   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic        cyc;
      logic        stb;
   } wb_req_t;

endpackage

// File: rtl/wb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ram_arbiter
// Two-master to one-slave Wishbone arbiter in front of a RAM. Round-robin on
// ties, grant held for the whole cyc, one IDLE cycle between owners, and a
// stall timeout that errors the owner and aborts its strobe.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mN_dat_i/adr_i/we_i/    master N request (N = 0, 1)
//   cyc_i/stb_i/sel_i/cti_i
//   mN_dat_o/ack_o/err_o    master N response
//   s_dat_o/adr_o/we_o/     forwarded request to the RAM slave
//   sel_o/cti_o/cyc_o/stb_o
//   s_dat_i, s_ack_i        slave response
//   grant_o                 one-hot current owner, 00 when idle
// ---------------------------------------------------------------------------
module wb_ram_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // master 0
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   input  logic [31:0]           m0_adr_i,
   input  logic                  m0_we_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic [3:0]            m0_sel_i,
   input  logic [2:0]            m0_cti_i,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   // master 1
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   input  logic [31:0]           m1_adr_i,
   input  logic                  m1_we_i,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic [3:0]            m1_sel_i,
   input  logic [2:0]            m1_cti_i,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   // slave
   output logic [DATA_WIDTH-1:0] s_dat_o,
   output logic [31:0]           s_adr_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic [2:0]            s_cti_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   input  logic                  s_ack_i,
   output logic [1:0]            grant_o
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic                  r_last;
   logic                  r_abort;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_g0;
   logic                  w_g1;
   wb_req_t               w_req0;
   wb_req_t               w_req1;
   wb_req_t               w_req;
   logic [DATA_WIDTH-1:0] w_dat;
   logic                  w_stb;
   logic                  w_ack;
   logic                  w_timeout;

   assign w_req0 = '{adr: m0_adr_i, we: m0_we_i, sel: m0_sel_i, cti: m0_cti_i,
                     cyc: m0_cyc_i, stb: m0_stb_i};
   assign w_req1 = '{adr: m1_adr_i, we: m1_we_i, sel: m1_sel_i, cti: m1_cti_i,
                     cyc: m1_cyc_i, stb: m1_stb_i};

   assign w_g0 = (r_state == ST_GRANT0);
   assign w_g1 = (r_state == ST_GRANT1);

   // Next-state: IDLE arbitrates (tie goes to the master not served last);
   // a grant is held until its cyc falls, and the return to IDLE never
   // grants in the same edge.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) w_next = r_last ? ST_GRANT0 : ST_GRANT1;
            else if (m0_cyc_i)        w_next = ST_GRANT0;
            else if (m1_cyc_i)        w_next = ST_GRANT1;
         end
         ST_GRANT0: if (!m0_cyc_i) w_next = ST_IDLE;
         ST_GRANT1: if (!m1_cyc_i) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Request mux: owner's signals pass through, everything zero in IDLE.
   always_comb begin
      w_req = '0;
      w_dat = '0;
      if (w_g0) begin
         w_req = w_req0;
         w_dat = m0_dat_i;
      end else if (w_g1) begin
         w_req = w_req1;
         w_dat = m1_dat_i;
      end
   end

   // Reset masks handshakes in the reset cycle itself so an in-flight
   // transfer is dropped silently.
   assign w_stb     = w_req.stb & ~r_abort & ~rst_i;
   assign w_ack     = s_ack_i & ~rst_i;
   // Fires on the TIMEOUT-th consecutive stall cycle; an ack in the same
   // cycle wins.
   assign w_timeout = w_stb & ~s_ack_i & (r_cnt == TO_LAST);

   assign s_dat_o  = w_dat;
   assign s_adr_o  = w_req.adr;
   assign s_we_o   = w_req.we;
   assign s_sel_o  = w_req.sel;
   assign s_cti_o  = w_req.cti;
   assign s_cyc_o  = w_req.cyc & ~r_abort & ~rst_i;
   assign s_stb_o  = w_stb;

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = w_g0 & w_ack;
   assign m1_ack_o = w_g1 & w_ack;
   assign m0_err_o = w_g0 & w_timeout;
   assign m1_err_o = w_g1 & w_timeout;

   assign grant_o  = {w_g1, w_g0};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_abort <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;

         if (r_state != ST_IDLE && w_next == ST_IDLE) begin
            r_last  <= (r_state == ST_GRANT1);
            r_abort <= 1'b0;
         end else if (w_timeout) begin
            r_abort <= 1'b1;
         end

         if (s_ack_i || (w_next != r_state) || !w_stb) r_cnt <= '0;
         else                                          r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data bus.
REQ-002 Parameter TIMEOUT, default 255: stall-cycle limit before a strobe is aborted; legal range 1..65535.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 mN_dat_i  in  DATA_WIDTH  write data from master N (N = 0, 1).
REQ-006 mN_dat_o  out  DATA_WIDTH  read data to master N.
REQ-007 mN_adr_i  in  32  byte address from master N.
REQ-008 mN_we_i, mN_cyc_i, mN_stb_i  in  1 each  write enable, cycle and strobe from master N.
REQ-009 mN_sel_i  in  4  byte selects; mN_cti_i  in  3  cycle type.
REQ-010 mN_ack_o, mN_err_o  out  1 each  acknowledge and error to master N.
REQ-011 s_dat_o, s_adr_o, s_we_o, s_sel_o, s_cti_o  out  (DATA_WIDTH, 32, 1, 4, 3)  forwarded to the RAM slave.
REQ-012 s_cyc_o, s_stb_o  out  1 each  cycle and strobe to the slave; s_dat_i, s_ack_i  in  (DATA_WIDTH, 1)  slave read data and acknowledge.
REQ-013 grant_o  out  2  one-hot current owner (bit N = master N); 00 when idle.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT0 and GRANT1.
REQ-015 In IDLE with exactly one mN_cyc_i high, the FSM SHALL go to GRANTN on the next edge.
REQ-016 In IDLE with both cyc high, the FSM SHALL grant the master not served last; last_q resets to 1, so master 0 wins the first tie.
REQ-017 Arbitration latency SHALL be one cycle: no slave strobe in the cycle a request first appears in IDLE.
REQ-018 In GRANTN, s_adr_o, s_dat_o, s_we_o, s_sel_o and s_cti_o SHALL equal master N's inputs combinationally.
REQ-019 In GRANTN, s_cyc_o SHALL be mN_cyc_i AND NOT abort_q, and s_stb_o SHALL be mN_stb_i AND NOT abort_q.
REQ-020 In IDLE, all s_* outputs SHALL be 0.
REQ-021 mN_ack_o SHALL be s_ack_i gated by the grant to master N; a non-granted master SHALL see ack=0 and err=0.
REQ-022 mN_dat_o SHALL equal s_dat_i for both masters, valid only when qualified by ack.
REQ-023 The grant SHALL be held while mN_cyc_i is high, including across multi-beat bursts regardless of cti.
REQ-024 When mN_cyc_i falls, the FSM SHALL return to IDLE on that edge and set last_q=N.
REQ-025 A new grant SHALL NOT be issued in the same cycle cyc falls, giving one IDLE cycle between owners.
REQ-026 A 16-bit stall counter SHALL clear on s_ack_i, on grant change and when s_stb_o is low, and otherwise increment each cycle s_stb_o is high without s_ack_i.
REQ-027 When the counter reaches TIMEOUT, the block SHALL pulse mN_err_o for exactly one cycle and set abort_q.
REQ-028 While abort_q is set, s_cyc_o and s_stb_o SHALL stay low; abort_q clears when the FSM returns to IDLE.
REQ-029 If s_ack_i and the timeout coincide, ack SHALL win: no error and the counter clears.
REQ-030 A master asserting stb without cyc SHALL be ignored.

Reset
REQ-031 rst_i SHALL force state=IDLE, last_q=1, counter=0, abort_q=0 and grant_o=00 on the next edge, including mid-transfer.
REQ-032 During and after reset, all ack, err, s_cyc_o and s_stb_o outputs SHALL be 0; any in-flight transfer is dropped without error.

Structure
REQ-033 State encodings and the counter width constant SHALL live in the shared package wb_pkg.
REQ-034 The block SHALL have no sub-modules; the timeout counter is inline.

Verification
REQ-035 Master 0 alone writes 0xDEADBEEF to 0x8 with sel=1111 -> grant_o=01 one cycle after cyc; slave sees the write; m0_ack_o pulses; m1_ack_o stays 0.
REQ-036 Both cyc rise together from reset -> master 0 served first; after m0 drops cyc there is one IDLE cycle, then grant_o=10.
REQ-037 Master 1 holds cyc across a 4-beat cti=010 burst while master 0 requests -> grant_o stays 10 until master 1 drops cyc.
REQ-038 TIMEOUT=4 and slave never acks -> m0_err_o pulses on the 4th stall cycle; s_stb_o drops next cycle; IDLE after m0 drops cyc.
REQ-039 rst_i asserted mid-burst -> next edge gives grant_o=00, all ack/err=0, s_cyc_o=0; first tie after reset goes to master 0.
